// File: rtl/scan_decoder_pkg.sv
// scan_decoder_pkg
//   Shared types and helpers for the scan_decoder block.
//   - state_e     : controller states (IDLE, DIRECT, SCAN)
//   - MODE_*      : encodings of the mode input
//   - onehot()    : index to one-hot vector, sized for the widest supported
//                   decoder (SEL_W up to IDX_MAX_W); callers cast it down to
//                   their own OUT_N.
package scan_decoder_pkg;

    localparam int IDX_MAX_W = 8;
    localparam int MAX_OUT_N = 1 << IDX_MAX_W;

    localparam logic MODE_DIRECT = 1'b0;
    localparam logic MODE_SCAN   = 1'b1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DIRECT = 2'd1,
        SCAN   = 2'd2
    } state_e;

    function automatic logic [MAX_OUT_N-1:0] onehot(input logic [IDX_MAX_W-1:0] idx);
        logic [MAX_OUT_N-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/scan_decoder_if.sv
// scan_decoder_if
//   Select handshake and output bundle of the scan decoder.
//   master (driver side) : en, mode, sel_in, sel_valid, dwell -> ; <- sel_ready, o, o_idx, wrap
//   slave  (decoder side): the mirror image.
//   OUT_N = 2**SEL_W output lines.
interface scan_decoder_if #(
    parameter int SEL_W   = 2,
    parameter int DWELL_W = 4
) ();
    localparam int OUT_N = 1 << SEL_W;

    logic               en;
    logic               mode;
    logic [SEL_W-1:0]   sel_in;
    logic               sel_valid;
    logic               sel_ready;
    logic [DWELL_W-1:0] dwell;
    logic [OUT_N-1:0]   o;
    logic [SEL_W-1:0]   o_idx;
    logic               wrap;

    modport master (
        output en, mode, sel_in, sel_valid, dwell,
        input  sel_ready, o, o_idx, wrap
    );

    modport slave (
        input  en, mode, sel_in, sel_valid, dwell,
        output sel_ready, o, o_idx, wrap
    );
endinterface

// File: rtl/scan_decoder_dwell_counter.sv
// dwell_counter
//   DWELL_W-bit loadable down-counter that times how long the scan stays on
//   each output line.
//   clk, rst     : clock, asynchronous active-high reset (counter -> 0)
//   load_i       : load load_val_i (has priority over dec_i)
//   dec_i        : decrement by one; holds at zero
//   load_val_i   : reload value (cycles per line minus 1)
//   zero_o       : counter currently reads zero
module dwell_counter #(
    parameter int DWELL_W = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load_i,
    input  logic               dec_i,
    input  logic [DWELL_W-1:0] load_val_i,
    output logic               zero_o
);
    logic [DWELL_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - DWELL_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == '0);
endmodule

// File: rtl/scan_decoder.sv
// scan_decoder
//   Registered SEL_W-to-2**SEL_W one-hot decoder with enable, a valid/ready
//   select handshake and an auto-scan mode with programmable dwell.
//   All outputs except sel_ready come straight from flops.
//   clk  : rising-edge clock
//   rst  : asynchronous active-high reset
//   bus  : scan_decoder_if slave port
//          en, mode, sel_in, sel_valid, dwell in; sel_ready, o, o_idx, wrap out
//   SEL_W must not exceed scan_decoder_pkg::IDX_MAX_W.
module scan_decoder
    import scan_decoder_pkg::*;
#(
    parameter int SEL_W   = 2,
    parameter int DWELL_W = 4
) (
    input logic           clk,
    input logic           rst,
    scan_decoder_if.slave bus
);
    localparam int               OUT_N    = 1 << SEL_W;
    localparam logic [SEL_W-1:0] LAST_IDX = SEL_W'(OUT_N - 1);

    state_e           state_q, state_d;
    logic [OUT_N-1:0] o_q, o_d;
    logic [SEL_W-1:0] idx_q, idx_d;
    logic             wrap_q, wrap_d;
    logic [SEL_W-1:0] idx_nxt;
    logic             ready;
    logic             cnt_load, cnt_dec, cnt_zero;

    // rst is folded in so the handshake closes the instant reset asserts.
    assign ready   = bus.en & (bus.mode == MODE_DIRECT) & ~rst;
    assign idx_nxt = idx_q + SEL_W'(1);   // wraps naturally at OUT_N

    always_comb begin
        state_d  = state_q;
        o_d      = o_q;
        idx_d    = idx_q;
        wrap_d   = 1'b0;
        cnt_load = 1'b0;
        cnt_dec  = 1'b0;

        if (!bus.en) begin
            state_d = IDLE;
            o_d     = '0;
            idx_d   = '0;
        end else if (bus.mode == MODE_DIRECT) begin
            // Leaving SCAN keeps the current line until a transfer arrives.
            state_d = DIRECT;
            if (bus.sel_valid && ready) begin
                o_d   = OUT_N'(onehot(IDX_MAX_W'(bus.sel_in)));
                idx_d = bus.sel_in;
            end
        end else begin
            state_d = SCAN;
            if (state_q != SCAN) begin
                // Entry into line 0 is a restart, not a wrap.
                o_d      = OUT_N'(onehot('0));
                idx_d    = '0;
                cnt_load = 1'b1;
            end else if (cnt_zero) begin
                o_d      = OUT_N'(onehot(IDX_MAX_W'(idx_nxt)));
                idx_d    = idx_nxt;
                wrap_d   = (idx_q == LAST_IDX);
                cnt_load = 1'b1;   // picks up the live dwell value
            end else begin
                cnt_dec = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            o_q     <= '0;
            idx_q   <= '0;
            wrap_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            o_q     <= o_d;
            idx_q   <= idx_d;
            wrap_q  <= wrap_d;
        end
    end

    dwell_counter #(
        .DWELL_W (DWELL_W)
    ) u_dwell (
        .clk        (clk),
        .rst        (rst),
        .load_i     (cnt_load),
        .dec_i      (cnt_dec),
        .load_val_i (bus.dwell),
        .zero_o     (cnt_zero)
    );

    assign bus.sel_ready = ready;
    assign bus.o         = o_q;
    assign bus.o_idx     = idx_q;
    assign bus.wrap      = wrap_q;
endmodule

// File: tb/tb_scan_decoder.sv
// tb_scan_decoder
//   Directed bench for scan_decoder: a vector table for direct decode,
//   scan with dwell=2, and mode/enable changes on a SEL_W=2 instance,
//   plus hand-written sequences for a mid-scan dwell change, asynchronous
//   reset, and dwell=0 scanning on a SEL_W=3 instance.
module tb_scan_decoder;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    scan_decoder_if #(.SEL_W(2), .DWELL_W(4)) bus  ();
    scan_decoder_if #(.SEL_W(3), .DWELL_W(4)) bus3 ();

    scan_decoder #(.SEL_W(2), .DWELL_W(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    scan_decoder #(.SEL_W(3), .DWELL_W(4)) dut3 (
        .clk (clk),
        .rst (rst),
        .bus (bus3)
    );

    typedef struct {
        logic       en;
        logic       mode;
        logic       vld;
        logic [1:0] sel;
        logic [3:0] dwell;
        logic [3:0] o;
        logic [1:0] idx;
        logic       wrap;
        logic       rdy;
    } vec_t;

    vec_t tbl [30];

    function automatic vec_t mk(input logic en, input logic mode, input logic vld,
                                input logic [1:0] sel, input logic [3:0] dwell,
                                input logic [3:0] o, input logic [1:0] idx,
                                input logic wrap, input logic rdy);
        vec_t v;
        v.en = en; v.mode = mode; v.vld = vld; v.sel = sel; v.dwell = dwell;
        v.o = o; v.idx = idx; v.wrap = wrap; v.rdy = rdy;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int exp_seq [8] = '{0, 0, 0, 1, 2, 3, 0, 1};
        int k3;

        bus.en = 1'b0; bus.mode = 1'b0; bus.sel_in = '0; bus.sel_valid = 1'b0; bus.dwell = '0;
        bus3.en = 1'b0; bus3.mode = 1'b0; bus3.sel_in = '0; bus3.sel_valid = 1'b0; bus3.dwell = '0;

        // ---- reset state ----
        step();
        step();
        check("rst_o",     32'(bus.o),         32'h0);
        check("rst_idx",   32'(bus.o_idx),     32'h0);
        check("rst_wrap",  32'(bus.wrap),      32'h0);
        check("rst_ready", 32'(bus.sel_ready), 32'h0);
        rst = 1'b0;
        bus.en = 1'b1;
        #1;
        check("rel_ready", 32'(bus.sel_ready), 32'h1);

        // ---- table: direct decode, scan dwell=2, mode/enable changes ----
        tbl[0]  = mk(1,0,1,2'd0,4'd2, 4'b0001,2'd0,0,1);
        tbl[1]  = mk(1,0,1,2'd1,4'd2, 4'b0010,2'd1,0,1);
        tbl[2]  = mk(1,0,1,2'd2,4'd2, 4'b0100,2'd2,0,1);
        tbl[3]  = mk(1,0,1,2'd3,4'd2, 4'b1000,2'd3,0,1);
        tbl[4]  = mk(1,0,0,2'd0,4'd2, 4'b1000,2'd3,0,1);
        tbl[5]  = mk(1,0,0,2'd2,4'd2, 4'b1000,2'd3,0,1);
        tbl[6]  = mk(1,1,1,2'd3,4'd2, 4'b0001,2'd0,0,0);
        tbl[7]  = mk(1,1,0,2'd0,4'd2, 4'b0001,2'd0,0,0);
        tbl[8]  = mk(1,1,1,2'd2,4'd2, 4'b0001,2'd0,0,0);
        tbl[9]  = mk(1,1,0,2'd0,4'd2, 4'b0010,2'd1,0,0);
        tbl[10] = mk(1,1,1,2'd3,4'd2, 4'b0010,2'd1,0,0);
        tbl[11] = mk(1,1,0,2'd0,4'd2, 4'b0010,2'd1,0,0);
        tbl[12] = mk(1,1,0,2'd0,4'd2, 4'b0100,2'd2,0,0);
        tbl[13] = mk(1,1,0,2'd0,4'd2, 4'b0100,2'd2,0,0);
        tbl[14] = mk(1,1,1,2'd0,4'd2, 4'b0100,2'd2,0,0);
        tbl[15] = mk(1,1,0,2'd0,4'd2, 4'b1000,2'd3,0,0);
        tbl[16] = mk(1,1,0,2'd0,4'd2, 4'b1000,2'd3,0,0);
        tbl[17] = mk(1,1,0,2'd0,4'd2, 4'b1000,2'd3,0,0);
        tbl[18] = mk(1,1,0,2'd0,4'd2, 4'b0001,2'd0,1,0);
        tbl[19] = mk(1,1,0,2'd0,4'd2, 4'b0001,2'd0,0,0);
        tbl[20] = mk(1,1,0,2'd0,4'd2, 4'b0001,2'd0,0,0);
        tbl[21] = mk(1,1,0,2'd0,4'd2, 4'b0010,2'd1,0,0);
        tbl[22] = mk(1,1,0,2'd0,4'd2, 4'b0010,2'd1,0,0);
        tbl[23] = mk(1,1,0,2'd0,4'd2, 4'b0010,2'd1,0,0);
        tbl[24] = mk(1,1,0,2'd0,4'd2, 4'b0100,2'd2,0,0);
        tbl[25] = mk(1,0,0,2'd0,4'd2, 4'b0100,2'd2,0,1);
        tbl[26] = mk(1,0,0,2'd3,4'd2, 4'b0100,2'd2,0,1);
        tbl[27] = mk(1,0,1,2'd1,4'd2, 4'b0010,2'd1,0,1);
        tbl[28] = mk(0,0,1,2'd3,4'd2, 4'b0000,2'd0,0,0);
        tbl[29] = mk(0,0,1,2'd2,4'd2, 4'b0000,2'd0,0,0);

        for (int i = 0; i < 30; i++) begin
            bus.en = tbl[i].en; bus.mode = tbl[i].mode; bus.sel_valid = tbl[i].vld;
            bus.sel_in = tbl[i].sel; bus.dwell = tbl[i].dwell;
            step();
            check($sformatf("vec%0d_o", i),     32'(bus.o),         32'(tbl[i].o));
            check($sformatf("vec%0d_idx", i),   32'(bus.o_idx),     32'(tbl[i].idx));
            check($sformatf("vec%0d_wrap", i),  32'(bus.wrap),      32'(tbl[i].wrap));
            check($sformatf("vec%0d_ready", i), 32'(bus.sel_ready), 32'(tbl[i].rdy));
        end

        // ---- mid-scan dwell change 3 -> 0 ----
        bus.en = 1'b1; bus.mode = 1'b1; bus.sel_valid = 1'b0; bus.dwell = 4'd3;
        step();
        check("dw_entry_idx", 32'(bus.o_idx), 32'h0);
        check("dw_entry_o",   32'(bus.o),     32'h1);
        bus.dwell = 4'd0;
        for (int i = 0; i < 8; i++) begin
            step();
            check($sformatf("dw%0d_idx", i),  32'(bus.o_idx), 32'(exp_seq[i]));
            check($sformatf("dw%0d_o", i),    32'(bus.o),     32'(1 << exp_seq[i]));
            check($sformatf("dw%0d_wrap", i), 32'(bus.wrap),  (i == 6) ? 32'h1 : 32'h0);
        end

        // ---- asynchronous reset mid-scan ----
        rst = 1'b1;
        #2;
        check("arst_o",     32'(bus.o),         32'h0);
        check("arst_idx",   32'(bus.o_idx),     32'h0);
        check("arst_wrap",  32'(bus.wrap),      32'h0);
        check("arst_ready", 32'(bus.sel_ready), 32'h0);
        bus.mode = 1'b0;
        step();
        rst = 1'b0;
        #1;
        check("arel_ready", 32'(bus.sel_ready), 32'h1);
        step();
        check("arel_o", 32'(bus.o), 32'h0);

        // ---- SEL_W=3, dwell=0: one line per cycle, wrap every 8 ----
        bus3.en = 1'b1; bus3.mode = 1'b1; bus3.dwell = 4'd0;
        for (int i = 0; i < 17; i++) begin
            step();
            k3 = i % 8;
            check($sformatf("s3_%0d_idx", i),  32'(bus3.o_idx), 32'(k3));
            check($sformatf("s3_%0d_o", i),    32'(bus3.o),     32'(1 << k3));
            check($sformatf("s3_%0d_wrap", i), 32'(bus3.wrap),  (i == 8 || i == 16) ? 32'h1 : 32'h0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/scan_decoder.md
Name: scan_decoder

Overview:
Parametrised registered N-to-2^N one-hot decoder, the next generation of the team's 2x4 gate-level decoder. It adds an enable, a valid/ready select handshake, and an auto-scan mode that steps the active output through all lines with a programmable dwell time. It drives row, chip-select and display-digit strobes, where outputs must be glitch-free and come straight from flops.

Parameters:
SEL_W, 2, select width; number of output lines OUT_N = 2**SEL_W (SEL_W >= 1)
DWELL_W, 4, width of the dwell-count input

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous active-high reset
en  input  1  block enable; low forces all outputs inactive
mode  input  1  0 = direct decode, 1 = auto-scan
sel_in  input  SEL_W  select value, direct mode; unsigned, MSB first
sel_valid  input  1  sel_in is valid this cycle
sel_ready  output  1  block accepts sel_in this cycle
dwell  input  DWELL_W  scan mode: cycles per line minus 1
o  output  OUT_N  registered one-hot output; o[i] active for select value i
o_idx  output  SEL_W  index of the active line (0 when o is all-zero)
wrap  output  1  one-cycle pulse when a scan steps from OUT_N-1 to 0

Behaviour:
- Reset (async assert, release synchronous to clk): o=0, o_idx=0, wrap=0, sel_ready=0, state=IDLE, dwell counter=0.
- FSM states: IDLE, DIRECT, SCAN. Evaluated every cycle, in this priority order:
  - en=0: any state goes to IDLE; o=0 and o_idx=0 on the next edge.
  - en=1 and mode=0: next state DIRECT.
  - en=1 and mode=1: next state SCAN.
- sel_ready is combinational: sel_ready = en & ~mode & ~rst. It is high in IDLE and DIRECT whenever en=1 and mode=0.
- Direct handshake:
  - Transfer occurs when sel_valid & sel_ready at a rising edge.
  - The next edge sets o = 1<<sel_in and o_idx = sel_in (latency 1 cycle).
  - With no transfer, o holds its value.
  - Back-to-back transfers on every cycle are supported.
- Entering SCAN (from IDLE or DIRECT):
  - First SCAN edge: o=1 (line 0), o_idx=0, dwell counter loaded with the dwell input.
- In SCAN, on each edge:
  - If counter != 0: decrement the counter; o holds.
  - If counter == 0: o_idx increments modulo OUT_N, o updates to match, and the counter reloads from the live dwell input.
  - dwell=0 advances one line per cycle.
- wrap=1 for exactly the cycle in which o_idx becomes 0 by stepping from OUT_N-1. The initial entry into line 0 does not raise wrap. wrap=0 in all other states.
- SCAN to DIRECT (mode falls, en=1): o and o_idx hold the current line until the first accepted transfer; wrap=0.
- sel_valid while sel_ready=0 (scan mode or en=0) is ignored and nothing is queued.
- o is always one-hot or all-zero. It is all-zero only in IDLE or after reset.
- Reset asserted mid-scan or mid-transfer clears o immediately (asynchronous), without waiting for a clock edge.
- Width rules:
  - OUT_N computed with SEL_W-bit index arithmetic; the index wraps naturally.
  - Dwell counter is DWELL_W bits and unsigned; no saturation is needed.

Decomposition:
- Shared package scan_decoder_pkg:
  - state enum {IDLE, DIRECT, SCAN}
  - MODE_DIRECT=0, MODE_SCAN=1 constants
  - function onehot(idx) returning OUT_N bits
- One natural sub-module: dwell_counter, a DWELL_W-bit loadable down-counter with a zero flag, used by the SCAN step.
- FSM and output registers stay in scan_decoder.

Test Plan:
- Reset, SEL_W=2: assert rst mid-operation -> o=0000, o_idx=0, wrap=0, sel_ready=0 asynchronously; release with en=1, mode=0 -> sel_ready=1.
- Direct decode, SEL_W=2: transfers of sel_in=0,1,2,3 on consecutive cycles -> o=0001, 0010, 0100, 1000 one cycle after each; sel_valid=0 afterwards -> o holds 1000.
- Scan, SEL_W=2, dwell=2: mode=1 -> o_idx sequence 0,0,0,1,1,1,2,2,2,3,3,3,0; wrap=1 only on the cycle o_idx returns to 0.
- Scan, dwell=0, SEL_W=3: o steps one line per cycle 0..7 then 0; wrap pulses every 8 cycles.
- Mode and enable changes: mid-scan at o_idx=2, drop mode -> o holds 0100 until a transfer of sel_in=1 gives 0010; then en=0 -> o=0000 next edge, sel_valid ignored.
- Mid-scan dwell change: dwell 3 -> 0 -> new value takes effect at the next reload; no line is skipped or repeated.
